// File: rtl/vital_alarm_monitor.sv
//==============================================================================
// Module   : vital_alarm_monitor
// Brief    : Checks valid sensor samples against live dataP/dataQ bounds and
//            raises a latched, acknowledgeable alarm after persistent violations.
//            Optional `ALARM_COUNT_EN adds a saturating alarm-entry counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vital_alarm_monitor #(
  parameter int PERSIST = 3,
  parameter int CLEAR   = 2
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [6:0] dataP,
  input  logic [6:0] dataQ,
  input  logic       sampleValid,
  input  logic [6:0] sampleData,
  input  logic       ack,
  output logic       alarm,
  output logic       alarmLow,
  output logic       alarmHigh,
  output logic       configError,
  output logic [1:0] state
`ifdef ALARM_COUNT_EN
  ,
  output logic [7:0] alarmCount
`endif
);

  localparam logic [1:0] S_NORMAL  = 2'b00;
  localparam logic [1:0] S_SUSPECT = 2'b01;
  localparam logic [1:0] S_ALARM   = 2'b10;
  localparam logic [1:0] S_HOLD    = 2'b11;

  localparam logic [3:0] C_PERSIST = 4'(PERSIST);
  localparam logic [3:0] C_CLEAR   = 4'(CLEAR);

  logic [1:0] r_state, w_state_nxt;
  logic [3:0] r_bad_cnt, w_bad_nxt;
  logic [3:0] r_good_cnt, w_good_nxt;
  logic       r_alarm, w_alarm_nxt;
  logic       r_low, w_low_nxt;
  logic       r_high, w_high_nxt;
  logic       r_cfg_err;

  logic w_low, w_high, w_oor, w_valid;

  assign w_low   = sampleData < dataP;
  assign w_high  = sampleData > dataQ;
  assign w_oor   = w_low | w_high;
  // A registered config error freezes the whole monitor, ack included.
  assign w_valid = sampleValid & ~r_cfg_err;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_NORMAL;
      r_bad_cnt  <= 4'd0;
      r_good_cnt <= 4'd0;
      r_alarm    <= 1'b0;
      r_low      <= 1'b0;
      r_high     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_good_cnt <= w_good_nxt;
      r_alarm    <= w_alarm_nxt;
      r_low      <= w_low_nxt;
      r_high     <= w_high_nxt;
      r_cfg_err  <= dataP > dataQ;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bad_nxt   = r_bad_cnt;
    w_good_nxt  = r_good_cnt;
    if (!r_cfg_err) begin
      case (r_state)
        S_NORMAL: begin
          if (w_valid && w_oor) begin
            w_bad_nxt   = 4'd1;
            w_state_nxt = (C_PERSIST == 4'd1) ? S_ALARM : S_SUSPECT;
          end
        end
        S_SUSPECT: begin
          if (w_valid) begin
            if (w_oor) begin
              w_bad_nxt = r_bad_cnt + 4'd1;
              if (r_bad_cnt + 4'd1 == C_PERSIST) w_state_nxt = S_ALARM;
            end else begin
              w_state_nxt = S_NORMAL;
            end
          end
        end
        default: begin
          // ALARM and HOLD share good-sample counting; the ack/auto-clear
          // decision looks at the count after this cycle's sample.
          if (w_valid)
            w_good_nxt = w_oor ? 4'd0 : ((r_good_cnt == 4'hF) ? 4'hF : r_good_cnt + 4'd1);
          if (r_state == S_HOLD || ack)
            w_state_nxt = (w_good_nxt >= C_CLEAR) ? S_NORMAL : S_HOLD;
        end
      endcase
      if (w_state_nxt == S_NORMAL) begin
        w_bad_nxt  = 4'd0;
        w_good_nxt = 4'd0;
      end
    end
  end

  always_comb begin
    w_alarm_nxt = (w_state_nxt == S_ALARM) || (w_state_nxt == S_HOLD);
    w_low_nxt   = r_low;
    w_high_nxt  = r_high;
    if (w_state_nxt == S_NORMAL) begin
      w_low_nxt  = 1'b0;
      w_high_nxt = 1'b0;
    end else if (w_valid && w_oor && (r_state != S_NORMAL || w_state_nxt == S_ALARM)) begin
      w_low_nxt  = w_low;
      w_high_nxt = ~w_low;
    end
  end

  assign alarm       = r_alarm;
  assign alarmLow    = r_low;
  assign alarmHigh   = r_high;
  assign configError = r_cfg_err;
  assign state       = r_state;

`ifdef ALARM_COUNT_EN
  logic [7:0] r_alarm_cnt;
  logic       w_enter;

  assign w_enter = ~r_state[1] && (w_state_nxt == S_ALARM);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)
      r_alarm_cnt <= 8'd0;
    else if (w_enter && r_alarm_cnt != 8'hFF)
      r_alarm_cnt <= r_alarm_cnt + 8'd1;
  end

  assign alarmCount = r_alarm_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/vital_alarm_monitor.md
Name: vital_alarm_monitor

Overview:
- Downstream consumer of the configuration stage. Takes the configured lower bound dataP and upper bound dataQ (7-bit each) and checks a stream of 7-bit patient sensor samples against them.
- Raises a latched, acknowledgeable alarm after a persistent out-of-range condition.
- Feeds the alarm/indicator logic of the healthcare system.

Parameters:
PERSIST, 3, consecutive out-of-range valid samples required to raise the alarm (legal 1..15)
CLEAR, 2, consecutive in-range valid samples required before the alarm may clear (legal 1..15)

Ports:
clock  input  1  system clock, rising-edge
resetN  input  1  asynchronous, active-low reset
dataP  input  7  lower threshold from the configuration stage
dataQ  input  7  upper threshold from the configuration stage
sampleValid  input  1  qualifies sampleData for one cycle
sampleData  input  7  sensor reading
ack  input  1  operator acknowledge, level sampled each cycle
alarm  output  1  alarm active
alarmLow  output  1  latest violation was below dataP
alarmHigh  output  1  latest violation was above dataQ
configError  output  1  dataP > dataQ, registered
state  output  2  FSM state: 00 NORMAL, 01 SUSPECT, 10 ALARM, 11 HOLD

Behaviour:
- Reset (resetN=0, asynchronous): state=NORMAL. alarm, alarmLow, alarmHigh and configError are 0. badCnt=0, goodCnt=0 (4-bit internal counters). Reset mid-alarm clears everything immediately.
- Classification is unsigned and applies to a valid sample only:
  - low: sampleData < dataP
  - high: sampleData > dataQ
  - equality with either bound is in range
  - thresholds are used live, with no internal copy
- configError is registered each cycle as (dataP > dataQ). While it is set:
  - valid samples are ignored
  - counters and state hold
  - no new alarm is raised; an existing alarm stays latched.
- All outputs are registered. The FSM acts only on cycles with sampleValid=1, except for ack handling.
- NORMAL:
  - out-of-range sample: badCnt=1; go to ALARM if PERSIST==1, else SUSPECT
  - in-range sample: stay.
- SUSPECT:
  - out-of-range sample: badCnt+1; on reaching PERSIST go to ALARM
  - in-range sample: badCnt=0, go to NORMAL
  - no valid sample: hold.
- Entry to ALARM: alarm=1 on the clock edge that samples the PERSIST-th violation, visible the following cycle. Low and high violations mix freely toward PERSIST.
- alarmLow/alarmHigh are one-hot while alarm=1. Each out-of-range sample in SUSPECT, ALARM or HOLD updates them to the latest direction.
- ALARM:
  - in-range sample: goodCnt+1, saturating at 15
  - out-of-range sample: goodCnt=0
  - ack=1 with goodCnt >= CLEAR: go to NORMAL
  - ack=1 with goodCnt < CLEAR: go to HOLD
  - ack in the same cycle as a valid sample: the ack decision uses the count after the sample is applied.
- HOLD (acknowledged, alarm still 1): counts in-range samples as in ALARM. goodCnt reaching CLEAR moves to NORMAL without a further ack. An out-of-range sample resets goodCnt but stays in HOLD. ack is ignored.
- Exit to NORMAL: alarm, alarmLow, alarmHigh, badCnt and goodCnt all clear in the same edge.
- ack in NORMAL or SUSPECT has no effect.

Optional Feature:
ALARM_COUNT_EN
- Defined:
  - adds output alarmCount, 8 bits, listed after state
  - increments on every NORMAL/SUSPECT-to-ALARM transition
  - saturates at 255; reset to 0 only by resetN.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
1. Threshold edges (dataP=20, dataQ=100): valid samples 20, 100, 50 -> state stays 00, alarm=0.
2. Persistence (PERSIST=3): samples 10, 110, 5 back to back.
   - state 01 after the first and second samples
   - alarm=1 with alarmLow=1, alarmHigh=0 the cycle after 5
   - SUSPECT then sample 50 -> state returns to 00, badCnt cleared.
3. Acknowledge paths (CLEAR=2):
   - in ALARM: ack with no in-range samples -> state 11, alarm stays 1; samples 60, 61 -> state 00, alarm=0 after the second
   - separate run: 60, 61 in ALARM, then ack -> direct to 00
   - ack in the same cycle as sample 61 also goes directly to 00.
4. Config error: dataP=90, dataQ=40 -> configError=1 next cycle; samples 0 and 127 produce no state change. Restore dataP=20 -> configError=0 and monitoring resumes.
5. Reset: assert resetN=0 asynchronously mid-clock while in ALARM -> all outputs 0 immediately, state 00. With ALARM_COUNT_EN, three alarm entries give alarmCount=3, and a reset returns it to 0.
